// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter increment logic.
// Holds the controller state encoding and the PCL wrap constant.
package pc_pkg;

    // Controller states: IDLE accepts requests, CARRY/FIXUP update PCH.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CARRY = 2'd1,
        FIXUP = 2'd2
    } pc_state_t;

    // Highest PCL value; incrementing from here carries into PCH.
    localparam logic [7:0] PCL_MAX = 8'hFF;

endpackage

// File: rtl/pc_byte_adder.sv
// 8-bit adder shared by the PCL increment and the relative branch.
// b may be an unsigned increment or a signed two's-complement offset;
// the caller interprets carry_out together with the sign of b.
module pc_byte_adder
    import pc_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       carry_out
);

    logic [8:0] w_full_s;

    // Nine-bit add so the page carry falls out of the top bit.
    always_comb begin
        w_full_s  = {1'b0, a} + {1'b0, b};
        sum       = w_full_s[7:0];
        carry_out = w_full_s[8];
    end

endmodule

// File: rtl/pc_increment_logic.sv
// Next-PC generator for an 8-bit-per-half program counter.
// Handles jump, PC+1 with a one-cycle PCH carry, and (optionally)
// relative branches with a one-cycle PCH page fixup.
// Optional feature macro: PC_BRANCH_EN enables branch/offset and FIXUP.
// Without it, branch and offset are ignored and page_cross stays 0.
module pc_increment_logic
    import pc_pkg::*;
(
    input  logic       clk_2,
    input  logic       reset,
    input  logic [7:0] pcl_in,
    input  logic [7:0] pch_in,
    input  logic       inc,
    input  logic       jump,
    input  logic [7:0] adl_in,
    input  logic [7:0] adh_in,
    input  logic       branch,
    input  logic [7:0] offset,
    output logic [7:0] pcl_out,
    output logic [7:0] pch_out,
    output logic       load_pcl,
    output logic       load_pch,
    output logic       busy,
    output logic       page_cross
);

    pc_state_t  r_state;
    logic [7:0] w_add_b;
    logic [7:0] w_sum;
    logic       w_carry;
    logic       w_accept;

`ifdef PC_BRANCH_EN
    logic       r_fwd;     // direction of the pending page fixup
    logic       w_cross;   // branch leaves the current page

    // Branch uses the offset operand unless a jump outranks it.
    always_comb begin
        if (branch && !jump) begin
            w_add_b = offset;
        end else begin
            w_add_b = 8'h01;
        end
    end

    // Forward crossing carries out; backward crossing fails to carry.
    always_comb begin
        if (offset[7]) begin
            w_cross = !w_carry;
        end else begin
            w_cross = w_carry;
        end
    end
`else
    logic w_unused_s;

    // Only the increment operand exists when branching is compiled out.
    always_comb begin
        w_add_b    = 8'h01;
        w_unused_s = ^{branch, offset};
    end
`endif

    pc_byte_adder u_adder (
        .a         (pcl_in),
        .b         (w_add_b),
        .sum       (w_sum),
        .carry_out (w_carry)
    );

    // Requests count only in IDLE and not in the cycle busy is shown,
    // so anything presented alongside busy is dropped rather than queued.
    always_comb begin
        w_accept = (r_state == IDLE) && !busy;
    end

    // Controller FSM with all outputs registered; strobes default low.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            pcl_out    <= 8'h00;
            pch_out    <= 8'h00;
            load_pcl   <= 1'b0;
            load_pch   <= 1'b0;
            busy       <= 1'b0;
            page_cross <= 1'b0;
`ifdef PC_BRANCH_EN
            r_fwd      <= 1'b0;
`endif
        end else begin
            load_pcl   <= 1'b0;
            load_pch   <= 1'b0;
            busy       <= 1'b0;
            page_cross <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (jump) begin
                            pcl_out  <= adl_in;
                            pch_out  <= adh_in;
                            load_pcl <= 1'b1;
                            load_pch <= 1'b1;
                        end
`ifdef PC_BRANCH_EN
                        else if (branch) begin
                            pcl_out  <= w_sum;
                            load_pcl <= 1'b1;
                            if (w_cross) begin
                                page_cross <= 1'b1;
                                r_fwd      <= !offset[7];
                                r_state    <= FIXUP;
                            end
                        end
`endif
                        else if (inc) begin
                            pcl_out  <= w_sum;
                            load_pcl <= 1'b1;
                            if (w_carry) begin
                                r_state <= CARRY;
                            end
                        end
                    end
                end
                CARRY: begin
                    pch_out  <= pch_in + 8'h01;
                    load_pch <= 1'b1;
                    busy     <= 1'b1;
                    r_state  <= IDLE;
                end
`ifdef PC_BRANCH_EN
                FIXUP: begin
                    if (r_fwd) begin
                        pch_out <= pch_in + 8'h01;
                    end else begin
                        pch_out <= pch_in - 8'h01;
                    end
                    load_pch <= 1'b1;
                    busy     <= 1'b1;
                    r_state  <= IDLE;
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_increment_logic.sv
// Directed self-checking bench for pc_increment_logic.
// Observed vector = {pcl_out, pch_out, load_pcl, load_pch, busy, page_cross}.
module tb_pc_increment_logic;

    logic       clk_2;
    logic       reset;
    logic [7:0] pcl_in, pch_in, adl_in, adh_in, offset;
    logic       inc, jump, branch;
    logic [7:0] pcl_out, pch_out;
    logic       load_pcl, load_pch, busy, page_cross;
    logic [19:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    pc_increment_logic dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .pcl_in     (pcl_in),
        .pch_in     (pch_in),
        .inc        (inc),
        .jump       (jump),
        .adl_in     (adl_in),
        .adh_in     (adh_in),
        .branch     (branch),
        .offset     (offset),
        .pcl_out    (pcl_out),
        .pch_out    (pch_out),
        .load_pcl   (load_pcl),
        .load_pch   (load_pch),
        .busy       (busy),
        .page_cross (page_cross)
    );

    assign obs = {pcl_out, pch_out, load_pcl, load_pch, busy, page_cross};

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic test_reset();
        @(posedge clk_2); #1;
        if (obs !== 20'h0) begin n_err++; $display("FAIL reset_state got %h want %h", obs, 20'h0); end
        n_cmp++;
        // first request on the first edge with reset low
        reset = 1'b0; pcl_in = 8'h34; pch_in = 8'h12; inc = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'h35, 8'h00, 4'b1000}) begin n_err++; $display("FAIL inc_basic got %h want %h", obs, {8'h35, 8'h00, 4'b1000}); end
        n_cmp++;
        inc = 1'b0;
        @(posedge clk_2); #1;
        if (obs !== {8'h35, 8'h00, 4'b0000}) begin n_err++; $display("FAIL idle_hold got %h want %h", obs, {8'h35, 8'h00, 4'b0000}); end
        n_cmp++;
    endtask

    task automatic test_carry();
        pcl_in = 8'hFF; pch_in = 8'h12; inc = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'h00, 4'b1000}) begin n_err++; $display("FAIL carry_c1 got %h want %h", obs, {8'h00, 8'h00, 4'b1000}); end
        n_cmp++;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'h13, 4'b0110}) begin n_err++; $display("FAIL carry_c2 got %h want %h", obs, {8'h00, 8'h13, 4'b0110}); end
        n_cmp++;
        // inc still high during the busy cycle: must be dropped
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'h13, 4'b0000}) begin n_err++; $display("FAIL busy_drop got %h want %h", obs, {8'h00, 8'h13, 4'b0000}); end
        n_cmp++;
        inc = 1'b0;
    endtask

    task automatic test_wrap();
        pcl_in = 8'hFF; pch_in = 8'hFF; inc = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'h13, 4'b1000}) begin n_err++; $display("FAIL wrap_c1 got %h want %h", obs, {8'h00, 8'h13, 4'b1000}); end
        n_cmp++;
        inc = 1'b0;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'h00, 4'b0110}) begin n_err++; $display("FAIL wrap_c2 got %h want %h", obs, {8'h00, 8'h00, 4'b0110}); end
        n_cmp++;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'h00, 4'b0000}) begin n_err++; $display("FAIL wrap_idle got %h want %h", obs, {8'h00, 8'h00, 4'b0000}); end
        n_cmp++;
    endtask

    task automatic test_jump();
        pcl_in = 8'hFF; pch_in = 8'h12; adh_in = 8'hC0; adl_in = 8'h00;
        jump = 1'b1; inc = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'hC0, 4'b1100}) begin n_err++; $display("FAIL jump_prio got %h want %h", obs, {8'h00, 8'hC0, 4'b1100}); end
        n_cmp++;
        jump = 1'b0; inc = 1'b0;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'hC0, 4'b0000}) begin n_err++; $display("FAIL jump_no_carry got %h want %h", obs, {8'h00, 8'hC0, 4'b0000}); end
        n_cmp++;
    endtask

    task automatic test_reset_mid_carry();
        pcl_in = 8'hFF; pch_in = 8'h12; inc = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'hC0, 4'b1000}) begin n_err++; $display("FAIL rst_carry_c1 got %h want %h", obs, {8'h00, 8'hC0, 4'b1000}); end
        n_cmp++;
        inc = 1'b0; reset = 1'b1;
        #1;
        if (obs !== 20'h0) begin n_err++; $display("FAIL rst_async got %h want %h", obs, 20'h0); end
        n_cmp++;
        @(posedge clk_2); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_2); #1;
            if (obs !== 20'h0) begin n_err++; $display("FAIL rst_abandon[%0d] got %h want %h", i, obs, 20'h0); end
            n_cmp++;
        end
    endtask

`ifdef PC_BRANCH_EN
    task automatic test_branch();
        pcl_in = 8'hF0; pch_in = 8'h12; offset = 8'h20; branch = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'h10, 8'h00, 4'b1001}) begin n_err++; $display("FAIL br_fwd_c1 got %h want %h", obs, {8'h10, 8'h00, 4'b1001}); end
        n_cmp++;
        branch = 1'b0;
        @(posedge clk_2); #1;
        if (obs !== {8'h10, 8'h13, 4'b0110}) begin n_err++; $display("FAIL br_fwd_c2 got %h want %h", obs, {8'h10, 8'h13, 4'b0110}); end
        n_cmp++;
        @(posedge clk_2); #1;
        pcl_in = 8'h10; pch_in = 8'h12; offset = 8'hE0; branch = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'hF0, 8'h13, 4'b1001}) begin n_err++; $display("FAIL br_bwd_c1 got %h want %h", obs, {8'hF0, 8'h13, 4'b1001}); end
        n_cmp++;
        branch = 1'b0;
        @(posedge clk_2); #1;
        if (obs !== {8'hF0, 8'h11, 4'b0110}) begin n_err++; $display("FAIL br_bwd_c2 got %h want %h", obs, {8'hF0, 8'h11, 4'b0110}); end
        n_cmp++;
        @(posedge clk_2); #1;
        // negative offset staying in page (carry out, offset<0)
        pcl_in = 8'h20; offset = 8'hF0; branch = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'h10, 8'h11, 4'b1000}) begin n_err++; $display("FAIL br_nocross got %h want %h", obs, {8'h10, 8'h11, 4'b1000}); end
        n_cmp++;
        branch = 1'b0;
        @(posedge clk_2); #1;
        if (obs !== {8'h10, 8'h11, 4'b0000}) begin n_err++; $display("FAIL br_nocross_idle got %h want %h", obs, {8'h10, 8'h11, 4'b0000}); end
        n_cmp++;
    endtask
`else
    task automatic test_branch();
        pcl_in = 8'hF0; pch_in = 8'h12; offset = 8'h20; branch = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'h00, 8'h00, 4'b0000}) begin n_err++; $display("FAIL br_ignored got %h want %h", obs, {8'h00, 8'h00, 4'b0000}); end
        n_cmp++;
        inc = 1'b1;
        @(posedge clk_2); #1;
        if (obs !== {8'hF1, 8'h00, 4'b1000}) begin n_err++; $display("FAIL br_inc_only got %h want %h", obs, {8'hF1, 8'h00, 4'b1000}); end
        n_cmp++;
        inc = 1'b0; branch = 1'b0;
        @(posedge clk_2); #1;
        if (obs !== {8'hF1, 8'h00, 4'b0000}) begin n_err++; $display("FAIL br_idle got %h want %h", obs, {8'hF1, 8'h00, 4'b0000}); end
        n_cmp++;
    endtask
`endif

    initial begin
        reset = 1'b1; inc = 1'b0; jump = 1'b0; branch = 1'b0;
        pcl_in = 8'h00; pch_in = 8'h00; adl_in = 8'h00; adh_in = 8'h00; offset = 8'h00;
        test_reset();
        test_carry();
        test_wrap();
        test_jump();
        test_reset_mid_carry();
        test_branch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
